pc_fetch_stage: RTL

- Fetch stage that owns the architectural PC register and drives the instruction-memory request.
- Captures fetched instructions into the IF/ID pipeline register.
- Consumes the redirect target produced by the downstream next-PC/branch logic, which resolves in ID.
- Feeds the captured PC+2 and instruction to decode, handles stalls, flushes and HLT, and tolerates multi-cycle memory latency.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/pc_fetch_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and helpers for the PC fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [OP_W-1:0]    HALT_OP   = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HALTED  = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that arrived while decode was stalled.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc_plus2,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc_plus2
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_plus2;

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus2 <= '0;
    end else if (i_clear) begin
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc_plus2 <= i_pc_plus2;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc_plus2 = r_pc_plus2;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory requests and fills IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus2,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, r_req_addr, r_if_id_pc_plus2;
  logic [INSTR_W-1:0] r_if_id_instr;
  logic               r_if_id_valid, r_halted;

  logic               w_req, w_mem_accept, w_skid_accept, w_skid_load, w_accept;
  logic               w_skid_valid, w_skid_clear;
  logic [INSTR_W-1:0] w_skid_instr, w_acc_instr;
  logic [ADDR_W-1:0]  w_skid_pc2, w_acc_pc2, w_pc_plus2, w_redirect_tgt;

  assign w_pc_plus2     = r_pc + ADDR_W'(2);
  assign w_redirect_tgt = redirect_pc & ~ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle control; redirect outranks stall and accept.
  always_comb begin
    w_state_nxt   = r_state;
    w_req         = 1'b0;
    w_mem_accept  = 1'b0;
    w_skid_accept = 1'b0;
    w_skid_load   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_req = !stall && !w_skid_valid;
        if (redirect) begin
          if (w_req && !imem_ready) w_state_nxt = ST_DISCARD;
        end else if (w_skid_valid && !stall) begin
          w_skid_accept = 1'b1;
          if (is_halt(w_skid_instr)) w_state_nxt = ST_HALTED;
        end else if (w_req && imem_ready) begin
          w_mem_accept = 1'b1;
          if (is_halt(imem_rdata)) w_state_nxt = ST_HALTED;
        end else if (w_req) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (redirect) begin
          w_state_nxt = imem_ready ? ST_FETCH : ST_DISCARD;
        end else if (imem_ready) begin
          if (stall) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_mem_accept = 1'b1;
            w_state_nxt  = is_halt(imem_rdata) ? ST_HALTED : ST_FETCH;
          end
        end
      end
      ST_DISCARD: begin
        w_req = 1'b1;
        if (imem_ready) w_state_nxt = ST_FETCH;
      end
      ST_HALTED: begin
        if (redirect) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign w_accept     = w_mem_accept | w_skid_accept;
  assign w_acc_instr  = w_skid_accept ? w_skid_instr : imem_rdata;
  assign w_acc_pc2    = w_skid_accept ? w_skid_pc2 : w_pc_plus2;
  assign w_skid_clear = redirect | w_skid_accept;

  fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_skid_load),
    .i_clear    (w_skid_clear),
    .i_instr    (imem_rdata),
    .i_pc_plus2 (w_pc_plus2),
    .o_valid    (w_skid_valid),
    .o_instr    (w_skid_instr),
    .o_pc_plus2 (w_skid_pc2)
  );

  // PC, outstanding-address and IF/ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc             <= RESET_PC;
      r_req_addr       <= RESET_PC;
      r_if_id_valid    <= 1'b0;
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_pc_plus2 <= '0;
      r_halted         <= 1'b0;
    end else begin
      r_halted <= (w_state_nxt == ST_HALTED);
      if (r_state == ST_FETCH) r_req_addr <= r_pc;
      if (redirect) begin
        r_pc          <= w_redirect_tgt;
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= NOP_INSTR;
      end else if (w_accept) begin
        r_if_id_valid    <= 1'b1;
        r_if_id_instr    <= w_acc_instr;
        r_if_id_pc_plus2 <= w_acc_pc2;
        if (!is_halt(w_acc_instr)) r_pc <= w_acc_pc2;
      end else if (!stall) begin
        r_if_id_valid <= 1'b0;
        r_if_id_instr <= NOP_INSTR;
      end
    end
  end

  // Request is suppressed while reset is held; address stays on the issued PC while outstanding.
  assign imem_req       = w_req & ~rst;
  assign imem_addr      = (r_state == ST_WAIT || r_state == ST_DISCARD) ? r_req_addr : r_pc;
  assign if_id_valid    = r_if_id_valid;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_pc_plus2 = r_if_id_pc_plus2;
  assign halted         = r_halted;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_bubbles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_accept && r_perf_fetched != 32'hFFFF_FFFF)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (!r_if_id_valid && r_perf_bubbles != 32'hFFFF_FFFF)
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
